// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode hazard scoreboard.
package hazard_pkg;

    // Forwarding select value meaning "read the register file".
    localparam int unsigned SEL_RF   = 0;
    // Ready-stage codes: ALU results forward from entry 0, load results from entry 1.
    localparam int unsigned RDY_ALU  = 0;
    localparam int unsigned RDY_LOAD = 1;

    // Entry fields are stored at fixed maximum widths so the struct can live here.
    // Instances must keep REG_ADDR_WIDTH <= EntryWsMax and LAT_W <= EntryRdyMax.
    localparam int unsigned EntryWsMax  = 32;
    localparam int unsigned EntryRdyMax = 8;

    typedef struct packed {
        logic                   valid;
        logic [EntryWsMax-1:0]  ws;
        logic [EntryRdyMax-1:0] rdy;
    } entry_t;

    // Width of a per-port forwarding select (0 = register file, k+1 = entry k).
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of the ready-stage field, never narrower than one bit.
    function automatic int unsigned lat_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hazard_port_check.sv
// Per-read-port search over the pending-write entries: youngest match decides
// between forwarding and a hazard.
module hazard_port_check
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH     = 4,
    parameter int unsigned PIPE_DEPTH         = 3,
    parameter int unsigned FORWARD_ENABLE     = 1,
    parameter int unsigned ZERO_REG_HARDWIRED = 0,
    localparam int unsigned SEL_W             = sel_w(PIPE_DEPTH)
) (
    input  entry_t [PIPE_DEPTH-1:0]     entries_i,
    input  logic                        re_i,
    input  logic [REG_ADDR_WIDTH-1:0]   rs_i,
    output logic                        hazard_o,
    output logic [SEL_W-1:0]            fwd_sel_o
);

    logic                  zero_blocked;
    logic [PIPE_DEPTH-1:0] match;

    assign zero_blocked = (ZERO_REG_HARDWIRED != 0) && (rs_i == '0);

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
        assign match[k] = entries_i[k].valid && re_i && !zero_blocked &&
                          (entries_i[k].ws == EntryWsMax'(rs_i));
    end

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hazard_o  = 1'b0;
        fwd_sel_o = SEL_W'(SEL_RF);
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            if (match[k]) begin
                // Result not yet available at this stage, or forwarding disabled.
                hazard_o  = (FORWARD_ENABLE == 0) || (EntryRdyMax'(k) < entries_i[k].rdy);
                fwd_sel_o = hazard_o ? SEL_W'(SEL_RF) : SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes, produces
// per-port forwarding selects or a stall, and counts stall cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH     = 4,
    parameter int unsigned NUM_READ_PORTS     = 2,
    parameter int unsigned PIPE_DEPTH         = 3,
    parameter int unsigned FORWARD_ENABLE     = 1,
    parameter int unsigned ZERO_REG_HARDWIRED = 0,
    parameter int unsigned STALL_CNT_WIDTH    = 16,
    localparam int unsigned SEL_W             = sel_w(PIPE_DEPTH),
    localparam int unsigned LAT_W             = lat_w(PIPE_DEPTH)
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_decode_valid,
    input  logic [NUM_READ_PORTS-1:0]            i_decode_re,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] i_decode_rs,
    input  logic                                 i_decode_we,
    input  logic [REG_ADDR_WIDTH-1:0]            i_decode_ws,
    input  logic [LAT_W-1:0]                     i_decode_rdy,
    input  logic                                 i_hold,
    input  logic [PIPE_DEPTH:0]                  i_flush_mask,
    output logic                                 o_stall,
    output logic [NUM_READ_PORTS*SEL_W-1:0]      o_fwd_sel,
    output logic [STALL_CNT_WIDTH-1:0]           o_stall_count
);

    entry_t [PIPE_DEPTH-1:0]      entries_q, entries_d;
    entry_t [PIPE_DEPTH-1:0]      entries_killed;
    entry_t                       push_entry;
    logic [NUM_READ_PORTS-1:0]    port_hazard;
    logic                         decode_killed;
    logic [STALL_CNT_WIDTH-1:0]   stall_count_q, stall_count_d;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        hazard_port_check #(
            .REG_ADDR_WIDTH     (REG_ADDR_WIDTH),
            .PIPE_DEPTH         (PIPE_DEPTH),
            .FORWARD_ENABLE     (FORWARD_ENABLE),
            .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
        ) u_check (
            .entries_i (entries_q),
            .re_i      (i_decode_re[p]),
            .rs_i      (i_decode_rs[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .hazard_o  (port_hazard[p]),
            .fwd_sel_o (o_fwd_sel[p*SEL_W +: SEL_W])
        );
    end

    assign decode_killed = i_flush_mask[PIPE_DEPTH];
    assign o_stall       = i_decode_valid && !decode_killed && (|port_hazard);
    assign o_stall_count = stall_count_q;

    // Entry pushed at the edge; a stalled or flushed decode becomes a bubble.
    always_comb begin
        push_entry       = '0;
        push_entry.valid = i_decode_valid && i_decode_we && !o_stall && !decode_killed;
        push_entry.ws    = EntryWsMax'(i_decode_ws);
        push_entry.rdy   = EntryRdyMax'(i_decode_rdy);
    end

    // Kill flushed instructions where they sit now, then shift, so the kill
    // travels with the instruction rather than with the slot.
    always_comb begin
        entries_killed = entries_q;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            if (i_flush_mask[k]) begin
                entries_killed[k].valid = 1'b0;
            end
        end
        entries_d = entries_killed;
        if (!i_hold) begin
            for (int k = int'(PIPE_DEPTH) - 1; k > 0; k--) begin
                entries_d[k] = entries_killed[k-1];
            end
            entries_d[0] = push_entry;
        end
    end

    // Saturating stall counter, frozen while the pipeline is held.
    always_comb begin
        stall_count_d = stall_count_q;
        if (o_stall && !i_hold && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset that overrides flush and hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            entries_q     <= '0;
            stall_count_q <= '0;
        end else begin
            entries_q     <= entries_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against the selected instance.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [1:0]  dec_re;
    logic [7:0]  dec_rs;
    logic        dec_we;
    logic [3:0]  dec_ws;
    logic [1:0]  dec_rdy;
    logic        hold;
    logic [3:0]  flush;

    logic        a_stall;
    logic [3:0]  a_fwd;
    logic [15:0] a_cnt;
    logic        b_stall;
    logic [3:0]  b_fwd;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut;
        string       name;
        logic        stall;
        logic [1:0]  fwd0;
        logic [1:0]  fwd1;
        int unsigned count;
    } exp_t;

    exp_t exp_q[$];

    // Default configuration: forwarding on, 16-bit counter.
    hazard_scoreboard u_dut_a (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_decode_valid (dec_valid),
        .i_decode_re    (dec_re),
        .i_decode_rs    (dec_rs),
        .i_decode_we    (dec_we),
        .i_decode_ws    (dec_ws),
        .i_decode_rdy   (dec_rdy),
        .i_hold         (hold),
        .i_flush_mask   (flush),
        .o_stall        (a_stall),
        .o_fwd_sel      (a_fwd),
        .o_stall_count  (a_cnt)
    );

    // No forwarding, 2-bit counter for saturation.
    hazard_scoreboard #(
        .FORWARD_ENABLE  (0),
        .STALL_CNT_WIDTH (2)
    ) u_dut_b (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_decode_valid (dec_valid),
        .i_decode_re    (dec_re),
        .i_decode_rs    (dec_rs),
        .i_decode_we    (dec_we),
        .i_decode_ws    (dec_ws),
        .i_decode_rdy   (dec_rdy),
        .i_hold         (hold),
        .i_flush_mask   (flush),
        .o_stall        (b_stall),
        .o_fwd_sel      (b_fwd),
        .o_stall_count  (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of decode inputs shortly after the rising edge.
    task automatic step(input logic r, input logic v, input logic we, input logic [3:0] ws,
                        input logic [1:0] rdy, input logic [1:0] re, input logic [3:0] rs0,
                        input logic [3:0] rs1, input logic h, input logic [3:0] fl);
        @(posedge clk);
        #1;
        rst       = r;
        dec_valid = v;
        dec_we    = we;
        dec_ws    = ws;
        dec_rdy   = rdy;
        dec_re    = re;
        dec_rs    = {rs1, rs0};
        hold      = h;
        flush     = fl;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'b0000);
    endtask

    task automatic push_wr(input logic [3:0] ws, input logic [1:0] rdy);
        step(1'b0, 1'b1, 1'b1, ws, rdy, 2'b00, 4'd0, 4'd0, 1'b0, 4'b0000);
    endtask

    task automatic expect_out(input int dut, input string name, input logic stall,
                              input logic [1:0] f0, input logic [1:0] f1,
                              input int unsigned cnt);
        exp_t e;
        e.dut   = dut;
        e.name  = name;
        e.stall = stall;
        e.fwd0  = f0;
        e.fwd1  = f1;
        e.count = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic        act_stall;
        logic [1:0]  act_f0;
        logic [1:0]  act_f1;
        int unsigned act_cnt;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                act_stall = a_stall;
                act_f0    = a_fwd[1:0];
                act_f1    = a_fwd[3:2];
                act_cnt   = int'(a_cnt);
            end else begin
                act_stall = b_stall;
                act_f0    = b_fwd[1:0];
                act_f1    = b_fwd[3:2];
                act_cnt   = int'(b_cnt);
            end
            total++;
            if (act_stall !== e.stall || act_f0 !== e.fwd0 || act_f1 !== e.fwd1 ||
                act_cnt !== e.count) begin
                bad++;
                $display("FAIL %s: got stall=%0b fwd0=%0d fwd1=%0d count=%0d, want stall=%0b fwd0=%0d fwd1=%0d count=%0d",
                         e.name, act_stall, act_f0, act_f1, act_cnt,
                         e.stall, e.fwd0, e.fwd1, e.count);
            end
        end
    end

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_re = '0; dec_rs = '0; dec_we = 1'b0;
        dec_ws = '0; dec_rdy = '0; hold = 1'b0; flush = '0;

        step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd0, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "reset_a", 1'b0, 2'd0, 2'd0, 0);
        expect_out(1, "reset_b", 1'b0, 2'd0, 2'd0, 0);

        // ALU read-after-write walks entries 0..2 then retires.
        push_wr(4'd3, 2'd0);
        expect_out(0, "raw_push", 1'b0, 2'd0, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "raw_e0", 1'b0, 2'd1, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "raw_e1", 1'b0, 2'd2, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "raw_e2", 1'b0, 2'd3, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "raw_retired", 1'b0, 2'd0, 2'd0, 0);

        // Load-use: one stall cycle, then forward from entry 1 on port 1.
        push_wr(4'd5, 2'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b10, 4'd0, 4'd5, 1'b0, 4'b0000);
        expect_out(0, "lu_stall", 1'b1, 2'd0, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b10, 4'd0, 4'd5, 1'b0, 4'b0000);
        expect_out(0, "lu_fwd", 1'b0, 2'd0, 2'd2, 1);
        idle();

        // Youngest match wins: r2 in entries 0 and 2, r7 in entry 1.
        push_wr(4'd2, 2'd0);
        push_wr(4'd7, 2'd0);
        push_wr(4'd2, 2'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd2, 4'd7, 1'b0, 4'b0000);
        expect_out(0, "youngest", 1'b0, 2'd1, 2'd2, 1);
        idle();
        idle();

        // Hold freezes entries and counter during a load-use stall, then flush.
        push_wr(4'd9, 2'd0);
        push_wr(4'd6, 2'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd6, 4'd9, 1'b1, 4'b0000);
        expect_out(0, "hold_1", 1'b1, 2'd0, 2'd2, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd6, 4'd9, 1'b1, 4'b0000);
        expect_out(0, "hold_2", 1'b1, 2'd0, 2'd2, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd6, 4'd9, 1'b0, 4'b0011);
        expect_out(0, "flush_cycle", 1'b1, 2'd0, 2'd0, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd6, 4'd0, 1'b0, 4'b0000);
        expect_out(0, "flush_after", 1'b0, 2'd0, 2'd0, 2);
        idle();

        // Three live entries; decode flush suppresses the stall; then reset.
        push_wr(4'd1, 2'd0);
        push_wr(4'd2, 2'd0);
        push_wr(4'd3, 2'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd3, 4'd2, 1'b1, 4'b1000);
        expect_out(0, "decode_flush", 1'b0, 2'd0, 2'd2, 2);
        step(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd3, 4'd2, 1'b1, 4'b0111);
        expect_out(0, "pre_reset", 1'b1, 2'd0, 2'd2, 2);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b11, 4'd3, 4'd2, 1'b0, 4'b0000);
        expect_out(0, "post_reset", 1'b0, 2'd0, 2'd0, 0);

        // No-forwarding instance: full pipeline-depth stall, then saturation.
        step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'b0000);
        push_wr(4'd4, 2'd0);
        expect_out(1, "nf_push", 1'b0, 2'd0, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd4, 4'd0, 1'b0, 4'b0000);
        expect_out(1, "nf_stall1", 1'b1, 2'd0, 2'd0, 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd4, 4'd0, 1'b0, 4'b0000);
        expect_out(1, "nf_stall2", 1'b1, 2'd0, 2'd0, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd4, 4'd0, 1'b0, 4'b0000);
        expect_out(1, "nf_stall3", 1'b1, 2'd0, 2'd0, 2);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b01, 4'd4, 4'd0, 1'b0, 4'b0000);
        expect_out(1, "nf_clear", 1'b0, 2'd0, 2'd0, 3);
        push_wr(4'd8, 2'd0);
        expect_out(1, "sat_push", 1'b0, 2'd0, 2'd0, 3);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b10, 4'd0, 4'd8, 1'b0, 4'b0000);
        expect_out(1, "sat_stall1", 1'b1, 2'd0, 2'd0, 3);
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'b10, 4'd0, 4'd8, 1'b0, 4'b0000);
        expect_out(1, "sat_stall2", 1'b1, 2'd0, 2'd0, 3);
        idle();
        expect_out(1, "sat_final", 1'b0, 2'd0, 2'd0, 3);

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
